// File: rtl/mips_defs.sv
// mips_defs: shared MIPS opcode/funct encodings and reset PC
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/id_stage_gpr.sv
// gpr: 32x32 register file, two async reads with write-before-read bypass, $0 hardwired to zero
module gpr (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] r_mem [32];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    else if (we && wa != 5'd0) r_mem[wa] <= wd;
  always_comb begin
    rd1 = ra1 == 5'd0 ? 32'd0 : (we && wa == ra1) ? wd : r_mem[ra1];
    rd2 = ra2 == 5'd0 ? 32'd0 : (we && wa == ra2) ? wd : r_mem[ra2];
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID register, register file, decode, operand forwarding, branch resolution and hazard stall
module id_stage #(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_if,
  input  logic [31:0] pc_if,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_dst,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_result,
  output logic        pc_en,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        branch,
  output logic        zero,
  output logic        j,
  output logic        jal,
  output logic        jr,
  output logic [31:0] beq_npc,
  output logic [31:0] tr_rd1_id,
  output logic [31:0] rd2_id,
  output logic [31:0] imm_ext,
  output logic [4:0]  dst_id,
  output logic        bubble
);
  import mips_defs::*;
  logic [31:0] r_pc, r_instr, w_gpr1, w_gpr2;
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic w_addu, w_subu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_jr;
  logic w_use_rs, w_use_rt, w_ex_rs, w_ex_rt, w_ld_rs, w_ld_rt, w_stall;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_instr <= '0;
      r_pc    <= RESET_PC;
    end else if (pc_en) begin
      r_instr <= instr_if;
      r_pc    <= pc_if;
    end
  gpr u_gpr (
    .clk(clk), .reset(reset),
    .ra1(w_rs), .ra2(w_rt), .rd1(w_gpr1), .rd2(w_gpr2),
    .we(wb_we), .wa(wb_addr), .wd(wb_data)
  );
  always_comb begin
    w_op     = r_instr[31:26];
    w_fn     = r_instr[5:0];
    w_rs     = r_instr[25:21];
    w_rt     = r_instr[20:16];
    w_rd     = r_instr[15:11];
    w_imm    = r_instr[15:0];
    w_addu   = w_op == OP_RTYPE && w_fn == FN_ADDU;
    w_subu   = w_op == OP_RTYPE && w_fn == FN_SUBU;
    w_jr     = w_op == OP_RTYPE && w_fn == FN_JR;
    w_ori    = w_op == OP_ORI;
    w_lui    = w_op == OP_LUI;
    w_lw     = w_op == OP_LW;
    w_sw     = w_op == OP_SW;
    w_beq    = w_op == OP_BEQ;
    w_j      = w_op == OP_J;
    w_jal    = w_op == OP_JAL;
    w_use_rs = w_addu || w_subu || w_ori || w_lw || w_sw || w_beq || w_jr;
    w_use_rt = w_addu || w_subu || w_sw || w_beq;
    w_ex_rs  = ex_regwrite && ex_dst != 5'd0 && ex_dst == w_rs;
    w_ex_rt  = ex_regwrite && ex_dst != 5'd0 && ex_dst == w_rt;
    w_ld_rs  = mem_regwrite && mem_memtoreg && mem_dst != 5'd0 && mem_dst == w_rs;
    w_ld_rt  = mem_regwrite && mem_memtoreg && mem_dst != 5'd0 && mem_dst == w_rt;
    // branches resolve here, so any in-flight producer of their operands stalls them
    w_stall  = (ex_memtoreg && ((w_use_rs && w_ex_rs) || (w_use_rt && w_ex_rt)))
            || (w_beq && (w_ex_rs || w_ex_rt || w_ld_rs || w_ld_rt))
            || (w_jr && (w_ex_rs || w_ld_rs));
  end
  always_comb begin
    pc_id     = r_pc;
    instr_id  = r_instr;
    pc_en     = !w_stall;
    bubble    = w_stall;
    branch    = w_beq && !w_stall;
    j         = w_j && !w_stall;
    jal       = w_jal && !w_stall;
    jr        = w_jr && !w_stall;
    tr_rd1_id = w_rs == 5'd0 ? 32'd0
              : (mem_regwrite && !mem_memtoreg && mem_dst == w_rs) ? mem_result : w_gpr1;
    rd2_id    = w_rt == 5'd0 ? 32'd0
              : (mem_regwrite && !mem_memtoreg && mem_dst == w_rt) ? mem_result : w_gpr2;
    zero      = tr_rd1_id == rd2_id;
    beq_npc   = r_pc + {{14{w_imm[15]}}, w_imm, 2'b00};
    imm_ext   = w_ori ? {16'd0, w_imm} : w_lui ? {w_imm, 16'd0} : {{16{w_imm[15]}}, w_imm};
    dst_id    = (w_addu || w_subu) ? w_rd : (w_ori || w_lui || w_lw) ? w_rt : w_jal ? 5'd31 : 5'd0;
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors with a scoreboard queue checked by an independent monitor
module tb_id_stage;
  localparam int S_PCEN = 0, S_BUB = 1, S_BR = 2, S_ZERO = 3, S_J = 4, S_JAL = 5, S_JR = 6;
  localparam int S_NPC = 7, S_RD1 = 8, S_RD2 = 9, S_IMM = 10, S_DST = 11, S_INSTR = 12, S_PC = 13;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  logic clk = 0, reset = 1;
  logic [31:0] instr_if = 0, pc_if = 0, wb_data = 0, mem_result = 0;
  logic wb_we = 0, ex_regwrite = 0, ex_memtoreg = 0, mem_regwrite = 0, mem_memtoreg = 0;
  logic [4:0] wb_addr = 0, ex_dst = 0, mem_dst = 0;
  logic pc_en, branch, zero, j, jal, jr, bubble;
  logic [31:0] pc_id, instr_id, beq_npc, tr_rd1_id, rd2_id, imm_ext;
  logic [4:0] dst_id;
  exp_t q[$];
  event ev_s;
  int checks = 0, failures = 0;
  id_stage dut (
    .clk(clk), .reset(reset), .instr_if(instr_if), .pc_if(pc_if),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_dst(ex_dst),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_dst(mem_dst), .mem_result(mem_result),
    .pc_en(pc_en), .pc_id(pc_id), .instr_id(instr_id), .branch(branch), .zero(zero),
    .j(j), .jal(jal), .jr(jr), .beq_npc(beq_npc), .tr_rd1_id(tr_rd1_id), .rd2_id(rd2_id),
    .imm_ext(imm_ext), .dst_id(dst_id), .bubble(bubble)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] get(int s);
    case (s)
      S_PCEN:  return {31'd0, pc_en};
      S_BUB:   return {31'd0, bubble};
      S_BR:    return {31'd0, branch};
      S_ZERO:  return {31'd0, zero};
      S_J:     return {31'd0, j};
      S_JAL:   return {31'd0, jal};
      S_JR:    return {31'd0, jr};
      S_NPC:   return beq_npc;
      S_RD1:   return tr_rd1_id;
      S_RD2:   return rd2_id;
      S_IMM:   return imm_ext;
      S_DST:   return {27'd0, dst_id};
      S_INSTR: return instr_id;
      default: return pc_id;
    endcase
  endfunction
  initial forever begin
    @(ev_s);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = get(e.sel);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end
  task automatic ex(input string n, input int s, input logic [31:0] v);
    q.push_back('{n, s, v});
  endtask
  task automatic chk();
    @(negedge clk);
    -> ev_s;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    instr_if = ins;
    pc_if = pc;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    ex("rst_pc_en", S_PCEN, 1); ex("rst_bubble", S_BUB, 0); ex("rst_branch", S_BR, 0);
    ex("rst_zero", S_ZERO, 1); ex("rst_j", S_J, 0); ex("rst_jal", S_JAL, 0); ex("rst_jr", S_JR, 0);
    ex("rst_npc", S_NPC, 32'h3000); ex("rst_rd1", S_RD1, 0); ex("rst_rd2", S_RD2, 0);
    ex("rst_imm", S_IMM, 0); ex("rst_dst", S_DST, 0); ex("rst_instr", S_INSTR, 0); ex("rst_pc", S_PC, 32'h3000);
    chk();
    reset = 0;
    wb_we = 1; wb_addr = 3; wb_data = 5;
    load(32'h00601021, 32'h3004);
    wb_we = 0;
    ex("r3_read", S_RD1, 5); ex("addu_dst", S_DST, 2); ex("addu_pc", S_PC, 32'h3004);
    chk();
    ex_regwrite = 1; ex_memtoreg = 1; ex_dst = 3;
    ex("pre_rst_stall", S_BUB, 1);
    chk();
    reset = 1;
    ex("midrst_instr", S_INSTR, 0); ex("midrst_pc", S_PC, 32'h3000);
    ex("midrst_pc_en", S_PCEN, 1); ex("midrst_bubble", S_BUB, 0);
    chk();
    reset = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_dst = 0;
    load(32'h00601021, 32'h3004);
    ex("r3_cleared", S_RD1, 0);
    chk();
    wb_we = 1; wb_addr = 2; wb_data = 32'h77;
    load(32'h00231021, 32'h300C);
    wb_we = 0;
    ex_regwrite = 1; ex_memtoreg = 1; ex_dst = 1;
    instr_if = 32'h34040007; pc_if = 32'h3010;
    ex("lu_pc_en", S_PCEN, 0); ex("lu_bubble", S_BUB, 1); ex("lu_instr", S_INSTR, 32'h00231021);
    chk();
    tick();
    ex_regwrite = 0; ex_memtoreg = 0; ex_dst = 0;
    mem_regwrite = 1; mem_memtoreg = 1; mem_dst = 1;
    ex("lu_rel_pc_en", S_PCEN, 1); ex("lu_rel_bubble", S_BUB, 0);
    ex("lu_held_instr", S_INSTR, 32'h00231021); ex("lu_held_pc", S_PC, 32'h300C);
    chk();
    tick();
    mem_regwrite = 0; mem_memtoreg = 0; mem_dst = 0;
    ex("ori_instr", S_INSTR, 32'h34040007); ex("ori_imm", S_IMM, 7); ex("ori_dst", S_DST, 4);
    chk();
    load(32'h10220004, 32'h3008);
    instr_if = 0;
    ex_regwrite = 1; ex_dst = 1;
    ex("beq_ex_pc_en", S_PCEN, 0); ex("beq_ex_bubble", S_BUB, 1); ex("beq_ex_branch", S_BR, 0);
    chk();
    tick();
    ex_regwrite = 0; ex_dst = 0;
    mem_regwrite = 1; mem_dst = 1; mem_result = 32'h77;
    wb_we = 1; wb_addr = 1; wb_data = 32'h99;
    ex("beq_pc_en", S_PCEN, 1); ex("beq_branch", S_BR, 1); ex("beq_zero", S_ZERO, 1);
    ex("beq_npc", S_NPC, 32'h3018); ex("beq_rs_fwd", S_RD1, 32'h77); ex("beq_rt", S_RD2, 32'h77);
    chk();
    mem_regwrite = 0; mem_dst = 0; mem_result = 0; wb_we = 0;
    load(32'h00A00008, 32'h3010);
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
    ex("jr_flag", S_JR, 1); ex("jr_target", S_RD1, 32'h1234); ex("jr_j", S_J, 0);
    chk();
    wb_addr = 0; wb_data = 32'hFFFF;
    load(32'h34040000, 32'h3014);
    ex("r0_zero", S_RD1, 0); ex("r0_ori_dst", S_DST, 4);
    chk();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    load(32'h0C000C00, 32'h3018);
    ex("jal_flag", S_JAL, 1); ex("jal_j", S_J, 0); ex("jal_dst", S_DST, 31);
    chk();
    load(32'h1000FFFF, 32'h3004);
    ex("beq_neg_npc", S_NPC, 32'h3000); ex("beq_neg_branch", S_BR, 1); ex("beq_neg_zero", S_ZERO, 1);
    chk();
    load(32'h3C068001, 32'h3008);
    ex("lui_imm", S_IMM, 32'h80010000); ex("lui_dst", S_DST, 6);
    chk();
    load(32'hAC27FFFC, 32'h300C);
    ex_regwrite = 1; ex_memtoreg = 1; ex_dst = 7;
    ex("sw_imm", S_IMM, 32'hFFFFFFFC); ex("sw_dst", S_DST, 0); ex("sw_lu_pc_en", S_PCEN, 0);
    chk();
    ex_regwrite = 0; ex_memtoreg = 0; ex_dst = 0;
    load(32'h10220004, 32'h3020);
    mem_regwrite = 1; mem_memtoreg = 1; mem_dst = 2;
    ex("beq_memld_bubble", S_BUB, 1); ex("beq_memld_branch", S_BR, 0);
    chk();
    mem_regwrite = 0; mem_memtoreg = 0; mem_dst = 0;
    load(32'h20430005, 32'h3024);
    ex_regwrite = 1; ex_memtoreg = 1; ex_dst = 2;
    ex("illegal_pc_en", S_PCEN, 1); ex("illegal_dst", S_DST, 0); ex("illegal_imm", S_IMM, 5);
    chk();
    ex_regwrite = 0; ex_memtoreg = 0; ex_dst = 0;
    load(32'h08000010, 32'h3028);
    ex("j_flag", S_J, 1); ex("j_dst", S_DST, 0); ex("j_jal", S_JAL, 0);
    chk();
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage MIPS pipeline. It holds the IF/ID pipeline register and the 32×32 general register file (`gpr`). It resolves beq/j/jal/jr in ID using forwarded operands and detects load-use and branch-operand hazards. It sits directly downstream of IF, supplying every redirect and stall signal IF consumes, and feeds the ID/EX register. The architecture uses a delay slot: the instruction fetched behind a control transfer always executes, so this block never flushes IF/ID.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: value loaded into `pc_id` on reset.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_if` in 32: instruction fetched this cycle.
- `pc_if` in 32: PC+4 of the fetched instruction.
- `wb_we` in 1, `wb_addr` in 5, `wb_data` in 32: register-file write port from WB.
- `ex_regwrite` in 1, `ex_memtoreg` in 1, `ex_dst` in 5: destination info of the instruction in EX.
- `mem_regwrite` in 1, `mem_memtoreg` in 1, `mem_dst` in 5, `mem_result` in 32: destination info and ALU result of the instruction in MEM.
- `pc_en` out 1: 1 means PC and IF/ID advance; drives IF's PC write enable.
- `pc_id` out 32, `instr_id` out 32: IF/ID register contents.
- `branch`, `zero`, `j`, `jal`, `jr` out 1 each: redirect controls to IF.
- `beq_npc` out 32: `pc_id + (sext(imm16) << 2)`, modulo 2^32.
- `tr_rd1_id` out 32: forwarded rs value, used as the jr target.
- `rd2_id` out 32: forwarded rt value.
- `imm_ext` out 32: immediate, zero-extended for ori, shifted left 16 for lui, sign-extended otherwise.
- `dst_id` out 5: rd for addu/subu, rt for ori/lui/lw, 31 for jal, 0 otherwise.
- `bubble` out 1: ID/EX must load a nop this cycle.

## Operation
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, and nop (all-zero word). Any other encoding decodes as nop.
- IF/ID register update:
  - On reset: `instr_id` = 0, `pc_id` = `RESET_PC`.
  - Otherwise, if `pc_en`: load `instr_if` and `pc_if`. Else hold.
- GPR write: on a clock edge with `wb_we` and `wb_addr` ≠ 0. Writes to $0 are ignored and $0 always reads 0. Reset clears all 32 registers.
- Operand source, first match wins:
  1. address 0 → 0;
  2. `mem_regwrite` & !`mem_memtoreg` & `mem_dst` == addr → `mem_result`;
  3. `wb_we` & `wb_addr` == addr → `wb_data` (same-cycle bypass);
  4. otherwise the GPR array.
- `zero` = (forwarded rs == forwarded rt). `branch` = decoded beq.
- Sources used by the ID instruction:
  - rs: addu, subu, ori, lw, sw, beq, jr;
  - rt: addu, subu, sw, beq.
- `stall` (internal) is the OR of the following. A match always requires a nonzero destination.
  - Load-use: `ex_regwrite` & `ex_memtoreg` & `ex_dst` matches any used source.
  - Branch/jr operand in EX: `ex_regwrite` & `ex_dst` matches rs/rt of beq or rs of jr.
  - Load in MEM feeding branch/jr: `mem_regwrite` & `mem_memtoreg` & `mem_dst` matches rs/rt of beq or rs of jr.
- When `stall` is set:
  - `pc_en` = 0, `bubble` = 1;
  - `branch`, `j`, `jal`, `jr` forced to 0;
  - IF/ID holds its contents.

## Timing
- All outputs are combinational from the IF/ID register, the GPR array and the inputs. Decode adds zero cycles of latency.
- A stall lasts exactly until the hazard clears: at most 2 cycles for a beq whose operand comes from a lw in EX, otherwise 1 cycle.
- Reset values:
  - `pc_en` = 1, `bubble` = 0;
  - all redirect flags 0; `zero` = 1, since $0 == $0;
  - `beq_npc` = `RESET_PC`;
  - `tr_rd1_id`, `rd2_id`, `imm_ext`, `dst_id` all 0.
- Reset asserted mid-stall clears IF/ID immediately; the stall drops in the same cycle.
- A WB write and a read of the same register in the same cycle returns the new value.

## Structure
- Shared package `mips_defs`: opcode/funct constants (`OP_RTYPE`, `OP_ORI`, `OP_LUI`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_JAL`, `FN_ADDU`, `FN_SUBU`, `FN_JR`) and `RESET_PC`.
- One sub-module, `gpr`: 2 asynchronous read ports, 1 synchronous write port, asynchronous reset, internal write-before-read bypass.
- Decode, forwarding and hazard logic stay in `id_stage`.

## Test plan
- Reset mid-run after writing $3 = 5 → `instr_id` = 0, `pc_id` = 32'h3000, `pc_en` = 1, $3 reads 0.
- lw $1 in EX, ID = addu $2,$1,$3 → `pc_en` = 0 and `bubble` = 1 for 1 cycle, `instr_id` held; next cycle `pc_en` = 1.
- ID = beq $1,$2,+4 at `pc_id` = 32'h3008, $1 produced by addu in EX:
  - cycle 1: stall;
  - cycle 2: `mem_result` = $2 value → `zero` = 1, `branch` = 1, `beq_npc` = 32'h3018.
- Same cycle, `wb_we`=1, `wb_addr`=5, `wb_data`=32'h1234, ID = jr $5 → `jr` = 1, `tr_rd1_id` = 32'h1234.
- Write 32'hFFFF to $0 via WB, then ID = ori $4,$0,0 → `tr_rd1_id` = 0.
- ID = 32'h0C000C00 (jal) → `jal` = 1, `j` = 0, `dst_id` = 31; beq offset 16'hFFFF at `pc_id` 32'h3004 → `beq_npc` = 32'h3000.
